// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Constants shared between the instruction loader and the core controller.
//   - Core mode encodings driven by the controller on the 3-bit mode bus.
//   - Loader FSM state type.
//   - Instruction word returned for fetches outside the instruction memory.
// -----------------------------------------------------------------------------
package inst_loader_pkg;

    // Core mode encodings, shared with the core controller
    localparam logic [2:0] MODE_STALL = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_EXEC  = 3'd2;
    localparam logic [2:0] MODE_STOP  = 3'd3;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    // Instruction returned for out-of-range fetch addresses
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // True when a byte-address fetch pc lies inside a memory of 2**addr_w words
    function automatic logic pc_in_range(input logic [31:0] pc, input int addr_w);
        logic [31:0] upper;
        upper = pc >> (addr_w + 2);
        return (upper == 32'h0);
    endfunction

endpackage

// File: rtl/inst_bram.sv
// -----------------------------------------------------------------------------
// inst_bram
// Single-clock simple dual-port RAM holding the instruction image.
// One write port and one registered read port. A read and a write to the same
// address in the same cycle return the old contents (read-first), which is the
// behaviour block RAM primitives provide natively.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   word write address
//   wdata  in   word to write
//   raddr  in   word read address
//   rdata  out  registered read data, one cycle after raddr
// -----------------------------------------------------------------------------
module inst_bram #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Instruction-side front end of the core. In LOAD mode it consumes the program
// byte stream from the UART receiver (32-bit big-endian length header followed
// by that many big-endian instruction words) and writes it into an internal
// instruction RAM. In every mode it serves a registered instruction read for
// the fetch pc. done releases the core controller into EXEC.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   mode        in   core mode from the controller (STALL/LOAD/EXEC/STOP)
//   rx_data     in   received byte
//   rx_ready    in   single-cycle pulse, rx_data valid
//   rx_ferr     in   framing error on the current rx_ready byte
//   pc          in   fetch byte address
//   inst        out  instruction word for pc, one cycle after pc
//   done        out  program fully received, sticky until rst
//   err         out  sticky: framing error or length header larger than memory
//   word_count  out  number of words actually written to memory
// -----------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int            DEPTH    = 2 ** ADDR_W;
    localparam logic [31:0]   DEPTH32  = 32'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_WC = (ADDR_W + 1)'(DEPTH);

    loader_state_t state, state_n;

    logic [1:0]  byte_cnt;
    logic [23:0] shift;      // first three bytes of the current group
    logic [31:0] len;
    logic [31:0] widx;       // full 32-bit so oversize programs can still be counted out

    logic        receiving;
    logic        byte_ok;
    logic        ferr_hit;
    logic        group_end;
    logic [31:0] word;
    logic        abort;
    logic        wr_en;
    logic        last_word;

    logic [31:0] rdata;
    logic        rd_ok;
    logic        unused_pc_lsb;

    // -------------------------------------------------------------------------
    // Byte intake and word assembly
    // -------------------------------------------------------------------------
    assign receiving = (state == LEN) || (state == DATA);
    assign byte_ok   = receiving && rx_ready && !rx_ferr;
    assign ferr_hit  = receiving && rx_ready &&  rx_ferr;
    assign group_end = byte_ok && (byte_cnt == 2'd3);
    // The 4th byte is used straight off the bus so the word is ready on the
    // same edge that consumes it.
    assign word      = {shift, rx_data};
    assign abort     = receiving && (mode != MODE_LOAD);

    // Words beyond the physical memory are consumed but not stored.
    assign wr_en     = (state == DATA) && group_end && (widx < DEPTH32);
    assign last_word = (state == DATA) && group_end && ((widx + 32'd1) == len);

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (mode == MODE_LOAD) begin
                    state_n = LEN;
                end
            end
            LEN: begin
                if (group_end) begin
                    state_n = (word == 32'h0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (last_word) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Leaving LOAD mid-transfer wins over any transition; a write that
        // coincides with the abort has already been issued this cycle.
        if (abort) begin
            state_n = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Control and bookkeeping registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            len        <= 32'h0;
            widx       <= 32'h0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state <= state_n;

            if (state_n == DONE) begin
                done <= 1'b1;
            end

            if (ferr_hit) begin
                err <= 1'b1;
            end

            if ((state == LEN) && group_end) begin
                len <= word;
                if (word > DEPTH32) begin
                    err <= 1'b1;
                end
            end

            // The 2-bit counter wraps to 0 at each group boundary.
            if (byte_ok) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            if ((state == DATA) && group_end) begin
                widx <= widx + 32'd1;
            end

            // Saturation guards against repeated aborted loads.
            if (wr_en && (word_count != DEPTH_WC)) begin
                word_count <= word_count + 1'b1;
            end

            if (abort) begin
                byte_cnt <= 2'd0;
                widx     <= 32'h0;
            end
        end
    end

    // Shift register carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (byte_ok) begin
            shift <= {shift[15:0], rx_data};
        end
    end

    // -------------------------------------------------------------------------
    // Instruction memory and fetch path
    // -------------------------------------------------------------------------
    inst_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (widx[ADDR_W-1:0]),
        .wdata (word),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (rdata)
    );

    // rd_ok is registered alongside the RAM read; it forces a nop for
    // out-of-range pcs and for the cycle after reset, since the RAM output
    // register itself carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ok <= 1'b0;
        end else begin
            rd_ok <= pc_in_range(pc, ADDR_W);
        end
    end

    assign inst = rd_ok ? rdata : NOP_INST;

    // Byte offset within a word has no effect on the fetch.
    assign unused_pc_lsb = ^pc[1:0];

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        mode;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_ferr;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_ferr    (rx_ferr),
        .pc         (pc),
        .inst       (inst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: program stream seen as header + word list
    // phase: 0 waiting for LOAD, 1 reading header, 2 reading words, 3 complete
    // ------------------------------------------------------------------
    int          m_phase;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_n;
    int          m_words;
    bit          m_err, m_done;
    int          m_wc;
    logic [31:0] m_mem[DEPTH];
    bit          m_known[DEPTH];
    logic [31:0] m_inst;
    bit          m_inst_known;
    bit          started = 0;

    always @(posedge clk) begin
        int nxt;
        logic [31:0] w;
        if (rst) begin
            m_phase = 0; m_bytes.delete(); m_n = 0; m_words = 0;
            m_err = 0; m_done = 0; m_wc = 0;
            m_inst = 32'h0; m_inst_known = 1;
        end else begin
            // read sees memory before this edge's write
            if ((pc >> (ADDR_W + 2)) != 0) begin
                m_inst = 32'h0; m_inst_known = 1;
            end else begin
                m_inst = m_mem[pc[ADDR_W+1:2]];
                m_inst_known = m_known[pc[ADDR_W+1:2]];
            end
            if (m_phase == 1 || m_phase == 2) begin
                nxt = m_phase;
                if (rx_ready) begin
                    if (rx_ferr) m_err = 1;
                    else begin
                        m_bytes.push_back(rx_data);
                        if (m_bytes.size() == 4) begin
                            w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                            m_bytes.delete();
                            if (m_phase == 1) begin
                                m_n = w;
                                if (w > DEPTH) m_err = 1;
                                nxt = (w == 0) ? 3 : 2;
                            end else begin
                                if (m_words < DEPTH) begin
                                    m_mem[m_words] = w;
                                    m_known[m_words] = 1;
                                    if (m_wc < DEPTH) m_wc++;
                                end
                                m_words++;
                                if (m_words == m_n) nxt = 3;
                            end
                        end
                    end
                end
                if (mode != MODE_LOAD) begin
                    m_phase = 0; m_bytes.delete(); m_words = 0;
                end else begin
                    m_phase = nxt;
                end
            end else if (m_phase == 0 && mode == MODE_LOAD) begin
                m_phase = 1;
            end
            if (m_phase == 3) m_done = 1;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("word_count", 32'(word_count), 32'(m_wc));
            if (m_inst_known) check("inst", inst, m_inst);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ferr = 0);
        rx_data = b; rx_ferr = ferr; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; rx_ferr = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]);
        send_byte(w[15:8]);  send_byte(w[7:0]);
    endtask

    task automatic do_reset();
        rst = 1'b1; mode = MODE_STALL; rx_ready = 1'b0; rx_ferr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_load();
        mode = MODE_LOAD;
        tick();
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        tick();
        check(name, inst, exp);
    endtask

    logic [31:0] ovw[6];

    initial begin
        rst = 1'b1; mode = MODE_STALL; rx_data = 8'h0; rx_ready = 1'b0;
        rx_ferr = 1'b0; pc = 32'h0;
        tick(); tick();
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_wc", 32'(word_count), 32'h0);
        check("reset_inst", inst, 32'h0);
        rst = 1'b0;

        // Normal load
        start_load();
        send_word(32'h0000_0002);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
        check("normal_done", 32'(done), 32'h1);
        check("normal_wc", 32'(word_count), 32'h2);
        check("normal_err", 32'(err), 32'h0);
        read_check("normal_pc0", 32'h0, 32'h1122_3344);
        read_check("normal_pc4", 32'h4, 32'hAABB_CCDD);
        read_check("normal_pc6", 32'h6, 32'hAABB_CCDD);

        // Empty program, trailing bytes ignored
        pc = 32'h0;
        do_reset();
        start_load();
        send_word(32'h0);
        check("empty_done", 32'(done), 32'h1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("empty_wc", 32'(word_count), 32'h0);

        // Framing error mid-word: bad byte dropped
        do_reset();
        start_load();
        send_word(32'h1);
        send_byte(8'h55, 1'b1);
        check("ferr_err", 32'(err), 32'h1);
        send_word(32'h0102_0304);
        check("ferr_done", 32'(done), 32'h1);
        read_check("ferr_word", 32'h0, 32'h0102_0304);

        // Overflow: 6 words into 4-word memory
        pc = 32'h0;
        do_reset();
        start_load();
        send_word(32'h6);
        check("ovf_err_hdr", 32'(err), 32'h1);
        for (int i = 0; i < 6; i++) begin
            ovw[i] = $urandom;
            send_word(ovw[i]);
            if (i == 4) check("ovf_not_done", 32'(done), 32'h0);
        end
        check("ovf_done", 32'(done), 32'h1);
        check("ovf_wc", 32'(word_count), 32'h4);
        for (int i = 0; i < 4; i++) read_check("ovf_mem", 32'(i * 4), ovw[i]);

        // Abort after 2 data bytes, then reload
        pc = 32'h0;
        do_reset();
        start_load();
        send_word(32'h1);
        send_byte(8'h99); send_byte(8'h88);
        mode = MODE_STALL;
        tick(); tick();
        start_load();
        send_word(32'h1);
        send_word(32'hDEAD_BEEF);
        check("abort_done", 32'(done), 32'h1);
        check("abort_wc", 32'(word_count), 32'h1);
        read_check("abort_word", 32'h0, 32'hDEAD_BEEF);

        // Out-of-range fetch
        read_check("oor_fetch", 32'h8000_0000, 32'h0);

        // Read-first on concurrent write to mem[0]
        pc = 32'h0;
        do_reset();
        start_load();
        send_word(32'h1);
        send_word(32'h1234_5678);
        check("rf_old", inst, 32'hDEAD_BEEF);
        tick();
        check("rf_new", inst, 32'h1234_5678);

        // Randomized loads, checked every cycle by the model
        for (int iter = 0; iter < 8; iter++) begin
            int n;
            do_reset();
            start_load();
            n = $urandom_range(0, 6);
            send_word(32'(n));
            for (int b = 0; b < 4 * n; b++) begin
                pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) send_byte(8'($urandom), 1'b1);
                if (iter == 5 && b == 6) begin
                    mode = MODE_STALL; tick(); start_load();
                end
                send_byte(8'($urandom));
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            end
            for (int r = 0; r < 8; r++) begin
                pc = 32'($urandom_range(0, 19));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Instruction-side front end of the core, sitting directly upstream of the fetch/decode pipeline register.
- LOAD mode: consumes the program byte stream from uart_rx (length header followed by instruction words) and writes it into an internal instruction BRAM.
- All modes: serves a registered instruction read addressed by the fetch pc, driving the f_inst input of the fetch/decode register.
- Raises done to release the core controller into EXEC.

Parameters:
ADDR_W, 15, word-address width of instruction memory; depth = 2**ADDR_W words
DEPTH, 2**ADDR_W, number of stored words (derived; not overridden independently)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mode  in  3  core mode from controller (STALL/LOAD/EXEC/STOP)
rx_data  in  8  received byte from uart_rx
rx_ready  in  1  single-cycle pulse, rx_data valid
rx_ferr  in  1  framing error qualifier for the current rx_ready byte
pc  in  32  fetch byte address
inst  out  32  instruction word for pc, one cycle after pc
done  out  1  program fully received; sticky until rst
err  out  1  sticky error: framing error or length > DEPTH
word_count  out  ADDR_W+1  number of words actually stored in memory

Behaviour:
- Reset: state=IDLE, done=0, err=0, word_count=0, inst=0, byte counter=0, word index=0, length register=0. BRAM contents are not cleared.
- Byte order is big-endian: the first byte of each 4-byte group is bits [31:24]. A 32-bit shift register assembles each group.
- FSM states:
  - IDLE: if mode==LOAD, go to LEN.
  - LEN: accept 4 bytes into the length register N. After the 4th byte: if N==0, go to DONE; else go to DATA.
  - DATA: on every 4th byte, write the assembled word to mem[widx], then widx++. The write of word N-1 moves to DONE in the same cycle as the write.
  - DONE: done=1 and held. No further bytes are consumed.
- Only rx_ready pulses advance the byte counter. Bytes arriving in IDLE or DONE are ignored.
- rx_ferr=1 with rx_ready: the byte is discarded (counter does not advance) and err<=1.
- Overflow, N > DEPTH:
  - err<=1 when the length header is latched.
  - Words with widx >= DEPTH are consumed but not written.
  - word_count saturates at DEPTH.
  - done is still raised after N words.
- word_count increments on each actual memory write.
- Abort: if mode != LOAD while in LEN or DATA, return to IDLE next cycle and clear the byte counter and widx. Memory keeps its partial data; err and word_count are held.
- Read path:
  - inst <= mem[pc[ADDR_W+1:2]] every cycle, independent of mode; latency is 1 cycle.
  - pc[1:0] is ignored.
  - If pc[31:ADDR_W+2] != 0, inst <= 32'h0 (nop).
- Simultaneous write and read to the same address: read-first, inst returns the old word.
- Length width: N is 32 bits; comparison against DEPTH is unsigned.
- A write (DATA, 4th byte) and an abort in the same cycle: the write completes, then the FSM goes to IDLE.

Decomposition:
- The shared constant package (existing) holds:
  - mode encodings STALL=0, LOAD=1, EXEC=2, STOP=3, shared with the core controller;
  - an enum loader_state_t {IDLE, LEN, DATA, DONE};
  - NOP_INST = 32'h0.
- One sub-module, inst_bram: single-clock simple dual-port RAM (one write port, one registered read port, read-first, inferable as BRAM). The FSM, assembler and address checks stay in inst_loader.

Test Plan:
- Normal load: mode=LOAD, send 00 00 00 02, 11 22 33 44, AA BB CC DD -> done=1 within 1 cycle of the last byte, word_count=2, err=0. Then pc=0 gives inst=11223344 next cycle; pc=4 gives AABBCCDD; pc=6 gives AABBCCDD.
- Empty program: send 00 00 00 00 -> done=1 after the 4th byte, word_count=0. Extra bytes afterwards are ignored (word_count stays 0).
- Framing error: during DATA, pulse rx_ready with rx_ferr=1 on byte 0x55 -> err=1. The byte is skipped, so the next 4 good bytes 01 02 03 04 form word 01020304.
- Overflow, ADDR_W=2 (DEPTH=4): N=6 plus 6 words -> err=1 at header, word_count=4, done=1 after the 6th word, mem[0..3] equal the first 4 words.
- Abort: mode LOAD to STALL after 2 data bytes, then back to LOAD, send header N=1 and word 0xDEADBEEF -> word stored at pc=0, done=1.
- Out-of-range fetch and read-first: pc=32'h8000_0000 gives inst=0. A write to mem[0] concurrent with pc=0 returns the prior contents that cycle and the new word the following cycle.
